// File: rtl/muxn_switch_reg.sv
// N-way word selector feeding a registered valid/ready output stage with a
// one-entry skid buffer, so in_ready never depends combinationally on out_ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module muxn_switch_reg #(
  parameter int unsigned WIDTH = `DATA_WIDTH,
  parameter int unsigned NUM   = 4,
  parameter int unsigned SEL_W = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sel_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] sel_data_c;
  logic             sel_err_c;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q,  main_err_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q,  skid_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q,  in_ready_d;

  logic accept_c;
  logic drain_c;
  logic slot_free_c;

  // Out-of-range switch values fall back to word 0 and raise the error flag.
  always_comb begin : sel_mux
    sel_data_c = in_data[WIDTH-1:0];
    sel_err_c  = 1'b1;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data_c = in_data[k*WIDTH +: WIDTH];
        sel_err_c  = 1'b0;
      end
    end
  end

  assign accept_c    = in_valid & in_ready_q;
  assign drain_c     = main_valid_q & out_ready;
  assign slot_free_c = ~main_valid_q | drain_c;

  always_comb begin : next_state
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free_c) begin
      // Skid entry always moves up first so it is never overtaken.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_data_d  = sel_data_c;
        main_err_d   = sel_err_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_data_d  = sel_data_c;
      skid_err_d   = sel_err_c;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      main_valid_q <= main_valid_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Skid payload is qualified by skid_valid_q and carries no reset.
  always_ff @(posedge clk) begin : skid_data_reg
    skid_data_q <= skid_data_d;
  end

  assign out_data    = main_data_q;
  assign out_sel_err = main_err_q;
  assign out_valid   = main_valid_q;
  assign in_ready    = in_ready_q;

endmodule

// File: doc/muxn_switch_reg.md
# muxn_switch_reg

Parametrised N-way operand selector with a registered, flow-controlled output stage for the core datapath (forwarding and writeback select). It picks one of NUM input words by an encoded switch and delivers it through a one-entry output register backed by a one-entry skid buffer. A valid/ready handshake on both sides sustains full throughput under back-pressure. Out-of-range switch values fall back to input 0 and are flagged.

## Interface
- WIDTH, `DATA_WIDTH (32): width of each data word
- NUM, 4: number of selectable inputs, 2..16
- SEL_W, $clog2(NUM): switch width; must satisfy 2**SEL_W >= NUM
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NUM*WIDTH  flattened inputs; word k = in_data[k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  encoded switch
- in_valid  in  1  upstream word/switch valid
- in_ready  out  1  block can accept this cycle
- flush  in  1  synchronous pipeline flush
- out_data  out  WIDTH  selected word
- out_sel_err  out  1  in_sel was >= NUM for this word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts

## Operation
- Select: word = in_data[in_sel] if in_sel < NUM, else word 0 with sel_err=1. Selection is combinational on the input side; data and sel_err are registered together.
- State: main register (out_data, out_sel_err, out_valid) and skid register (skid_data, skid_err, skid_valid).
- in_ready = ~skid_valid. It is driven from a register and has no combinational path from out_ready.
- accept = in_valid & in_ready. drain = out_valid & out_ready.
- Per cycle, with flush=0:
  - Main slot free (~out_valid | drain) and skid_valid: main <= skid, skid_valid <= 0. accept cannot occur in this case.
  - Main slot free and ~skid_valid and accept: main <= selected word, out_valid <= 1.
  - Main slot free, nothing accepted or drained from skid: out_valid <= 0.
  - out_valid & ~out_ready & accept: skid <= selected word, skid_valid <= 1. The main register holds.
- flush=1 takes priority over everything:
  - out_valid <= 0 and skid_valid <= 0.
  - Any input presented that cycle is dropped.
  - A drain in the same cycle still counts as a completed transfer downstream.
- The data registers need no reset. The valid and error flags are reset.
- Ordering is strict FIFO. The skid entry is never overtaken.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_sel_err=0, out_data=0, skid_valid=0, so in_ready=1. After deassertion the first accept can occur on the first rising edge.
- Latency: a word accepted at edge n is presented on out_data/out_valid after edge n and is stable until drained.
- Throughput: 1 word/cycle while out_ready=1.
- Back-pressure: one word beyond the main register is absorbed. in_ready drops the cycle after the skid fills and rises the cycle after the skid empties.
- Output stability: while out_valid & ~out_ready, out_data and out_sel_err must not change. Verification asserts this.
- Reset mid-transfer discards both entries immediately. No partial output is permitted.
- Simultaneous drain and accept with the skid empty replaces the main entry in the same edge with no bubble.

## Test plan
- Reset release, NUM=4, WIDTH=32: in_data={0xDDDD_0003, 0xCCCC_0002, 0xBBBB_0001, 0xAAAA_0000}; sel 0,1,2,3 streamed with out_ready=1. Required: outputs 0xAAAA_0000, 0xBBBB_0001, 0xCCCC_0002, 0xDDDD_0003 on consecutive cycles, one cycle after each accept, sel_err=0.
- NUM=3 with in_sel=3: out_data = word 0, out_sel_err=1. The next word with in_sel=1 has out_sel_err=0.
- Back-pressure: stream words A,B,C with out_ready=0 from the cycle A appears. Required: A held stable, B captured in skid, in_ready=0 the following cycle, C stalled. Raise out_ready. Required: A,B,C emitted in order with no loss or duplication, and in_ready back to 1.
- flush while both entries are full and in_valid=1: the next cycle shows out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- rst_n pulsed low mid-stream with skid full: out_valid, out_sel_err, and in_ready reach 0/0/1 asynchronously. The stream restarts cleanly after release.
- Random valid/ready, NUM=16, WIDTH=8, 10k cycles: the scoreboard matches the selected words in order, and no output changes while stalled.
